// File: rtl/fpu_issue_seq.sv
// Issue/retire sequencer for the FPU: accepts one op per cycle, tracks in-flight
// ops in a shifting slot array, and retires results with their tag on one port.
module fpu_issue_seq #(
    parameter int W        = 32,
    parameter int TAG_W    = 4,
    parameter int LAT_ADD  = 2,
    parameter int LAT_MUL  = 1,
    parameter int LAT_DIV  = 4,
    parameter int LAT_SQRT = 3,
    localparam int MAX_AM  = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL,
    localparam int MAX_DS  = (LAT_DIV > LAT_SQRT) ? LAT_DIV : LAT_SQRT,
    localparam int MAX_LAT = (MAX_AM > MAX_DS) ? MAX_AM : MAX_DS,
    localparam int CNT_W   = $clog2(MAX_LAT) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fpu_ready,
    input  logic [2:0]       fpucontrol,
    input  logic [TAG_W-1:0] issue_tag,
    input  logic [W-1:0]     arg2,
    input  logic [W-1:0]     add_rs,
    input  logic [W-1:0]     sub_rs,
    input  logic [W-1:0]     mul_rs,
    input  logic [W-1:0]     div_rs,
    input  logic [W-1:0]     sqrt_rs,
    input  logic             flush,
    output logic             fpu_accept,
    output logic             fpu_valid,
    output logic [W-1:0]     fpuout,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] inflight
);

    localparam int NS = (MAX_LAT > 1) ? MAX_LAT - 1 : 1;

    if (LAT_ADD < 1 || LAT_MUL < 1 || LAT_DIV < 1 || LAT_SQRT < 1) begin : g_bad_lat
        $error("fpu_issue_seq: every unit latency must be at least 1");
    end

    // Bit MAX_LAT is a permanently empty phantom slot so v[L] needs no range guard.
    logic [MAX_LAT:1]  vld_q, vld_d;
    logic [2:0]        op_q  [1:NS];
    logic [2:0]        op_d  [1:NS];
    logic [TAG_W-1:0]  tag_q [1:NS];
    logic [TAG_W-1:0]  tag_d [1:NS];
    logic              valid_q, valid_d;
    logic [W-1:0]      out_q, out_d;
    logic [TAG_W-1:0]  otag_q, otag_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    int                lat;
    logic              blocked;

    function automatic int lat_of(input logic [2:0] op);
        case (op)
            3'd0, 3'd1: return LAT_ADD;
            3'd2:       return LAT_MUL;
            3'd3:       return LAT_DIV;
            3'd4:       return LAT_SQRT;
            default:    return 1;
        endcase
    endfunction

    function automatic logic [W-1:0] res_sel(input logic [2:0] op);
        case (op)
            3'd0:    return add_rs;
            3'd1:    return sub_rs;
            3'd2:    return mul_rs;
            3'd3:    return div_rs;
            3'd4:    return sqrt_rs;
            3'd5:    return {1'b0, arg2[W-2:0]};
            3'd6:    return arg2;
            default: return {~arg2[W-1], arg2[W-2:0]};
        endcase
    endfunction

    always_comb begin
        lat     = lat_of(fpucontrol);
        blocked = 1'b0;
        for (int k = 1; k <= MAX_LAT; k++) begin
            if (k == lat) blocked = vld_q[k];
        end
        fpu_accept = fpu_ready & ~flush & ~blocked;
    end

    always_comb begin
        vld_d   = '0;
        op_d    = op_q;
        tag_d   = tag_q;
        valid_d = 1'b0;
        out_d   = out_q;
        otag_d  = otag_q;
        cnt_d   = '0;
        for (int k = 1; k < MAX_LAT; k++) vld_d[k] = vld_q[k+1];
        for (int k = 1; k < NS; k++) begin
            op_d[k]  = op_q[k+1];
            tag_d[k] = tag_q[k+1];
        end
        if (fpu_accept && lat >= 2) begin
            for (int k = 1; k <= NS; k++) begin
                if (k == lat - 1) begin
                    vld_d[k] = 1'b1;
                    op_d[k]  = fpucontrol;
                    tag_d[k] = issue_tag;
                end
            end
        end
        if (vld_q[1]) begin
            valid_d = 1'b1;
            out_d   = res_sel(op_q[1]);
            otag_d  = tag_q[1];
        end else if (fpu_accept && lat == 1) begin
            valid_d = 1'b1;
            out_d   = res_sel(fpucontrol);
            otag_d  = issue_tag;
        end
        if (flush) begin
            vld_d   = '0;
            valid_d = 1'b0;
            out_d   = out_q;
            otag_d  = otag_q;
        end
        for (int k = 1; k <= MAX_LAT; k++) begin
            if (vld_d[k]) cnt_d = cnt_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q   <= '0;
            valid_q <= 1'b0;
            out_q   <= '0;
            otag_q  <= '0;
            cnt_q   <= '0;
        end else begin
            vld_q   <= vld_d;
            valid_q <= valid_d;
            out_q   <= out_d;
            otag_q  <= otag_d;
            cnt_q   <= cnt_d;
        end
    end

    // Slot payload is only meaningful under its valid bit, so it needs no reset.
    always_ff @(posedge clk) begin
        op_q  <= op_d;
        tag_q <= tag_d;
    end

    assign fpu_valid = valid_q;
    assign fpuout    = out_q;
    assign out_tag   = otag_q;
    assign inflight  = cnt_q;

endmodule

// File: tb/tb_fpu_issue_seq.sv
// Directed bench for fpu_issue_seq: table of single ops plus hand-built
// collision, out-of-order, flush and asynchronous-reset sequences.
module tb_fpu_issue_seq;

    localparam int W = 32;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             fpu_ready;
    logic [2:0]       fpucontrol;
    logic [TAG_W-1:0] issue_tag;
    logic [W-1:0]     arg2;
    logic [W-1:0]     add_rs, sub_rs, mul_rs, div_rs, sqrt_rs;
    logic             flush;
    logic             fpu_accept;
    logic             fpu_valid;
    logic [W-1:0]     fpuout;
    logic [TAG_W-1:0] out_tag;
    logic [2:0]       inflight;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fpu_issue_seq dut (
        .clk        (clk),
        .rst        (rst),
        .fpu_ready  (fpu_ready),
        .fpucontrol (fpucontrol),
        .issue_tag  (issue_tag),
        .arg2       (arg2),
        .add_rs     (add_rs),
        .sub_rs     (sub_rs),
        .mul_rs     (mul_rs),
        .div_rs     (div_rs),
        .sqrt_rs    (sqrt_rs),
        .flush      (flush),
        .fpu_accept (fpu_accept),
        .fpu_valid  (fpu_valid),
        .fpuout     (fpuout),
        .out_tag    (out_tag),
        .inflight   (inflight)
    );

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  tag;
        logic [31:0] a;
        logic [31:0] rs;
        int          lat;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_rs;
        add_rs  = 32'hA0D0_0001;
        sub_rs  = 32'hA0D0_0002;
        mul_rs  = 32'hA0D0_0003;
        div_rs  = 32'hA0D0_0004;
        sqrt_rs = 32'hA0D0_0005;
    endtask

    task automatic set_rs(input logic [2:0] op, input logic [31:0] v);
        case (op)
            3'd0: add_rs = v;
            3'd1: sub_rs = v;
            3'd2: mul_rs = v;
            3'd3: div_rs = v;
            3'd4: sqrt_rs = v;
            default: ;
        endcase
    endtask

    task automatic issue(input logic [2:0] op, input logic [3:0] tag);
        fpu_ready  = 1'b1;
        fpucontrol = op;
        issue_tag  = tag;
    endtask

    task automatic run_single(input vec_t v, input int idx);
        issue(v.op, v.tag);
        arg2 = v.a;
        for (int c = 0; c <= v.lat + 1; c++) begin
            idle_rs();
            if (c == v.lat - 1) set_rs(v.op, v.rs);
            #1;
            if (c == 0) chk($sformatf("v%0d_accept", idx), fpu_accept, 1);
            tick();
            fpu_ready = 1'b0;
            arg2      = 32'h1234_5678;
            chk($sformatf("v%0d_valid_c%0d", idx, c + 1), fpu_valid, (c + 1 == v.lat));
            if (c + 1 == v.lat) begin
                chk($sformatf("v%0d_out", idx), fpuout, v.exp);
                chk($sformatf("v%0d_tag", idx), out_tag, v.tag);
            end
        end
        chk($sformatf("v%0d_inflight", idx), inflight, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{3'd2, 4'd3,  32'h0,         32'h4040_0000, 1, 32'h4040_0000};
        vecs[1] = '{3'd0, 4'd5,  32'h0,         32'h3F80_0000, 2, 32'h3F80_0000};
        vecs[2] = '{3'd1, 4'd6,  32'h0,         32'hC000_0000, 2, 32'hC000_0000};
        vecs[3] = '{3'd4, 4'd7,  32'h0,         32'h3FB5_04F3, 3, 32'h3FB5_04F3};
        vecs[4] = '{3'd3, 4'd8,  32'h0,         32'h3EAA_AAAB, 4, 32'h3EAA_AAAB};
        vecs[5] = '{3'd5, 4'd9,  32'hBF80_0000, 32'h0,         1, 32'h3F80_0000};
        vecs[6] = '{3'd7, 4'd10, 32'hBF80_0000, 32'h0,         1, 32'h3F80_0000};
        vecs[7] = '{3'd6, 4'd11, 32'hBF80_0000, 32'h0,         1, 32'hBF80_0000};
        vecs[8] = '{3'd7, 4'd12, 32'h3F80_0000, 32'h0,         1, 32'hBF80_0000};

        rst = 1'b0; fpu_ready = 1'b0; flush = 1'b0;
        fpucontrol = 3'd0; issue_tag = '0; arg2 = '0;
        idle_rs();
        #12;
        chk("rst_valid", fpu_valid, 0);
        chk("rst_out", fpuout, 0);
        chk("rst_tag", out_tag, 0);
        chk("rst_inflight", inflight, 0);
        issue(3'd3, 4'd0);
        #1 chk("rst_accept", fpu_accept, 1);
        flush = 1'b1;
        #1 chk("rst_accept_flush", fpu_accept, 0);
        flush = 1'b0; fpu_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) run_single(vecs[i], i);

        // Collision: div then sqrt would share the same retire edge.
        idle_rs();
        issue(3'd3, 4'd1);
        #1 chk("col_div_accept", fpu_accept, 1);
        tick();
        issue(3'd4, 4'd2);
        #1 chk("col_sqrt_reject", fpu_accept, 0);
        tick();
        #1 chk("col_sqrt_retry", fpu_accept, 1);
        tick();
        fpu_ready = 1'b0;
        chk("col_inflight", inflight, 2);
        chk("col_valid_c3", fpu_valid, 0);
        div_rs = 32'h4444_4444;
        tick();
        chk("col_div_valid", fpu_valid, 1);
        chk("col_div_out", fpuout, 32'h4444_4444);
        chk("col_div_tag", out_tag, 1);
        chk("col_inflight_c4", inflight, 1);
        idle_rs();
        sqrt_rs = 32'h5555_5555;
        tick();
        chk("col_sqrt_valid", fpu_valid, 1);
        chk("col_sqrt_out", fpuout, 32'h5555_5555);
        chk("col_sqrt_tag", out_tag, 2);
        chk("col_inflight_c5", inflight, 0);
        idle_rs();
        tick();
        chk("col_valid_c6", fpu_valid, 0);

        // Out-of-order: mul issued after div retires first.
        issue(3'd3, 4'd1);
        #1 chk("ooo_div_accept", fpu_accept, 1);
        tick();
        issue(3'd2, 4'd2);
        mul_rs = 32'h2222_2222;
        #1 chk("ooo_mul_accept", fpu_accept, 1);
        tick();
        fpu_ready = 1'b0;
        idle_rs();
        chk("ooo_mul_valid", fpu_valid, 1);
        chk("ooo_mul_out", fpuout, 32'h2222_2222);
        chk("ooo_mul_tag", out_tag, 2);
        tick();
        chk("ooo_gap_valid", fpu_valid, 0);
        div_rs = 32'h1111_1111;
        tick();
        idle_rs();
        chk("ooo_div_valid", fpu_valid, 1);
        chk("ooo_div_out", fpuout, 32'h1111_1111);
        chk("ooo_div_tag", out_tag, 1);
        tick();
        chk("ooo_valid_c5", fpu_valid, 0);

        // Flush kills the add retiring on the flush edge.
        issue(3'd0, 4'd5);
        #1 chk("fl_add_accept", fpu_accept, 1);
        tick();
        issue(3'd3, 4'd6);
        flush  = 1'b1;
        add_rs = 32'h7777_7777;
        #1 chk("fl_reject", fpu_accept, 0);
        tick();
        flush = 1'b0; fpu_ready = 1'b0;
        idle_rs();
        chk("fl_valid", fpu_valid, 0);
        chk("fl_inflight", inflight, 0);
        chk("fl_out_hold", fpuout, 32'h1111_1111);
        chk("fl_tag_hold", out_tag, 1);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("fl_valid_after%0d", c), fpu_valid, 0);
        end

        // Asynchronous reset with three divs in flight.
        issue(3'd3, 4'd1);
        #1 chk("ar_div1_accept", fpu_accept, 1);
        tick();
        issue(3'd3, 4'd2);
        #1 chk("ar_div2_accept", fpu_accept, 1);
        tick();
        issue(3'd3, 4'd3);
        #1 chk("ar_div3_accept", fpu_accept, 1);
        tick();
        fpu_ready = 1'b0;
        chk("ar_inflight3", inflight, 3);
        div_rs = 32'h3333_3333;
        tick();
        chk("ar_pre_valid", fpu_valid, 1);
        chk("ar_pre_out", fpuout, 32'h3333_3333);
        chk("ar_pre_tag", out_tag, 1);
        chk("ar_pre_inflight", inflight, 2);
        #2 rst = 1'b0;
        #1;
        chk("ar_valid", fpu_valid, 0);
        chk("ar_out", fpuout, 0);
        chk("ar_tag", out_tag, 0);
        chk("ar_inflight", inflight, 0);
        div_rs = 32'h6666_6666;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        issue(3'd2, 4'd4);
        mul_rs = 32'h4040_0000;
        #1 chk("ar_mul_accept", fpu_accept, 1);
        tick();
        fpu_ready = 1'b0;
        chk("ar_mul_valid", fpu_valid, 1);
        chk("ar_mul_out", fpuout, 32'h4040_0000);
        chk("ar_mul_tag", out_tag, 4);
        chk("ar_mul_inflight", inflight, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("ar_quiet%0d", c), fpu_valid, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
